// File: rtl/window_stream_gen_if.sv
// Purpose : pixel-in / window-out handshake bundle for window_stream_gen.
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready on the pixel side, out_valid/out_ready on the window side.
// Ports   : master = pixel source + window consumer view, slave = generator view.
interface window_stream_gen_if #(
  parameter int DATA_W = 8,
  parameter int WIN    = 7
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_sof;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIN*WIN*DATA_W-1:0] out_window;
  logic [DATA_W-1:0]         out_center;
  logic                      out_last;
  logic                      sync_err;

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_window, out_center, out_last, sync_err
  );

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_window, out_center, out_last, sync_err
  );
endinterface

// File: rtl/window_stream_gen.sv
// Purpose : WIN x WIN sliding window over a LINE_W x FRAME_H raster, with centre pixel,
//           window-valid qualifier, end-of-frame mark and sof resync error pulse.
// Latency : 1 cycle from pixel accept to updated window/valid/last outputs.
// Backpressure: in_ready = !out_valid || out_ready; a held output freezes everything.
// Ports   : clk, reset (async, active-high), bus (window_stream_gen_if.slave).
module window_stream_gen #(
  parameter int DATA_W  = 8,
  parameter int WIN     = 7,
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480
) (
  input  logic                clk,
  input  logic                reset,
  window_stream_gen_if.slave  bus
);

  localparam int CW  = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
  localparam int RW  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int NL  = WIN - 1;
  localparam int MID = WIN / 2;

  logic [CW-1:0]     col_q, col_d, pos_col;
  logic [RW-1:0]     row_q, row_d, pos_row;
  logic              accept, qual, at_end;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              sync_err_q, sync_err_d;

  // Line memories: lm_q[0] holds the previous line, lm_q[k] the line k+1 back.
  logic [DATA_W-1:0] lm_q  [NL][LINE_W];
  logic [DATA_W-1:0] lm_rd [NL];
  logic [DATA_W-1:0] win_q [WIN][WIN];

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    pos_col     = col_q;
    pos_row     = row_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sync_err_d  = 1'b0;
    // An sof pixel is always placed at (0,0), whatever the counters say.
    if (bus.in_sof) begin
      pos_col = '0;
      pos_row = '0;
    end
    at_end = (pos_row == RW'(FRAME_H-1)) && (pos_col == CW'(LINE_W-1));
    qual   = (pos_row >= RW'(WIN-1)) && (pos_col >= CW'(WIN-1));
    if (accept) begin
      sync_err_d  = bus.in_sof && ((col_q != '0) || (row_q != '0));
      out_valid_d = qual;
      out_last_d  = qual && at_end;
      if (pos_col == CW'(LINE_W-1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(FRAME_H-1)) ? '0 : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Read-before-write at the current column gives the pixel one line older.
  always_comb begin
    for (int k = 0; k < NL; k++) lm_rd[k] = lm_q[k][pos_col];
  end

  // Not reset: stale lines are never exposed because qualification needs WIN-1 fresh rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lm_q[0][pos_col] <= bus.in_data;
      for (int k = 1; k < NL; k++) lm_q[k][pos_col] <= lm_rd[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN-1; c++) win_q[r][c] <= win_q[r][c+1];
      // Row WIN-2 takes the previous line, row 0 the oldest line.
      for (int r = 0; r < WIN-1; r++) win_q[r][WIN-1] <= lm_rd[WIN-2-r];
      win_q[WIN-1][WIN-1] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sync_err_q  <= sync_err_d;
    end
  end

  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < WIN; c++) begin : g_col
      assign bus.out_window[(r*WIN+c)*DATA_W +: DATA_W] = win_q[r][c];
    end
  end

  assign bus.out_center = win_q[MID][MID];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_window_stream_gen.sv
`timescale 1ns/1ps
module tb_window_stream_gen;
  localparam int DW = 8;
  localparam int WN = 3;
  localparam int LW = 4;
  localparam int FH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_stream_gen_if #(.DATA_W(DW), .WIN(WN)) bus ();

  window_stream_gen #(.DATA_W(DW), .WIN(WN), .LINE_W(LW), .FRAME_H(FH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [WN*WN*DW-1:0] win;
    logic [DW-1:0]       ctr;
    logic                last;
  } exp_t;

  typedef struct {
    logic          vld;
    logic          sof;
    logic [DW-1:0] dat;
    logic          ordy;
    logic          e_vld;
    logic [DW-1:0] e_ctr;
    logic          e_last;
    logic          e_irdy;
  } vec_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ctr_q[$];
  logic [DW-1:0] img [FH][LW];
  vec_t          tbl [17];
  int            mr, mc;
  int            n_chk = 0, n_pass = 0, n_hs = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: stores the frame image by raster position and cuts the expected
  // window straight out of it whenever the accepted pixel completes an in-frame block.
  task automatic model_accept(input logic [DW-1:0] d, input logic sof);
    int r, c;
    exp_t e;
    r = sof ? 0 : mr;
    c = sof ? 0 : mc;
    img[r][c] = d;
    if (r >= WN-1 && c >= WN-1) begin
      for (int wr = 0; wr < WN; wr++)
        for (int wc = 0; wc < WN; wc++)
          e.win[(wr*WN+wc)*DW +: DW] = img[r-WN+1+wr][c-WN+1+wc];
      e.ctr  = img[r-WN/2][c-WN/2];
      e.last = (r == FH-1) && (c == LW-1);
      exp_q.push_back(e);
    end
    c++;
    if (c == LW) begin
      c = 0;
      r++;
      if (r == FH) r = 0;
    end
    mr = r;
    mc = c;
  endtask

  // Inputs change only at posedge+1, so the negedge sees what the next edge will see.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        ctr_q.push_back(bus.out_center);
        if (exp_q.size() == 0) check("unexpected_window", 0, 1);
        else begin
          mon_e = exp_q.pop_front();
          check("stream_window", bus.out_window, mon_e.win);
          check("stream_centre", bus.out_center, mon_e.ctr);
          check("stream_last", bus.out_last, mon_e.last);
        end
      end
      if (bus.in_valid && bus.in_ready) model_accept(bus.in_data, bus.in_sof);
    end
  end

  function automatic logic [DW-1:0] pat(input int i);
    return DW'((i / LW) * 16 + (i % LW));
  endfunction

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_px(input logic [DW-1:0] d, input logic sof, input bit rnd);
    bit acc = 1'b0;
    int guard = 0;
    int gaps = 0;
    if (rnd) begin
      while ($urandom_range(1, 0) == 0 && gaps < 4) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        gaps++;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sof   = sof;
    while (!acc && guard < 200) begin
      if (rnd) bus.out_ready = 1'($urandom_range(1, 0));
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    check("accept_within_budget", acc, 1);
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < LW*FH; i++) send_px(base + pat(i), i == 0, rnd);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 17; i++) begin
      bus.in_valid  = tbl[i].vld;
      bus.in_sof    = tbl[i].sof;
      bus.in_data   = tbl[i].dat;
      bus.out_ready = tbl[i].ordy;
      @(posedge clk); #1;
      check($sformatf("%s_valid[%0d]", tag, i), bus.out_valid, tbl[i].e_vld);
      check($sformatf("%s_in_ready[%0d]", tag, i), bus.in_ready, tbl[i].e_irdy);
      check($sformatf("%s_last[%0d]", tag, i), bus.out_last, tbl[i].e_last);
      if (tbl[i].e_vld) check($sformatf("%s_centre[%0d]", tag, i), bus.out_center, tbl[i].e_ctr);
      if (i == 10) begin
        check($sformatf("%s_win_oldest", tag), bus.out_window[7:0], 8'h00);
        check($sformatf("%s_win_newest", tag), bus.out_window[WN*WN*DW-1 -: DW], 8'h22);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, c;
    for (int i = 0; i < 16; i++) begin
      r = i / LW;
      c = i % LW;
      tbl[i].vld    = 1'b1;
      tbl[i].sof    = (i == 0);
      tbl[i].dat    = pat(i);
      tbl[i].ordy   = 1'b1;
      tbl[i].e_vld  = (r >= 2) && (c >= 2);
      tbl[i].e_ctr  = DW'((r-1)*16 + (c-1));
      tbl[i].e_last = (i == 15);
      tbl[i].e_irdy = 1'b1;
    end
    tbl[16] = '{vld: 1'b0, sof: 1'b0, dat: 8'h00, ordy: 1'b1,
                e_vld: 1'b0, e_ctr: 8'h00, e_last: 1'b0, e_irdy: 1'b1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    mr = 0;
    mc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_window", bus.out_window, 0);
    check("rst_centre", bus.out_center, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_sync_err", bus.sync_err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;

    // Full frame from the table.
    n_hs = 0;
    run_table("s1");
    idle(2);
    check("s1_window_count", n_hs, 4);

    // Backpressure while centre 0x11 is presented.
    n_hs = 0;
    for (int i = 0; i < 11; i++) send_px(pat(i), i == 0, 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h23;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_in_ready[%0d]", k), bus.in_ready, 0);
      check($sformatf("bp_valid[%0d]", k), bus.out_valid, 1);
      check($sformatf("bp_centre[%0d]", k), bus.out_center, 8'h11);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_centre", bus.out_center, 8'h12);
    check("bp_release_valid", bus.out_valid, 1);
    for (int i = 12; i < 16; i++) send_px(pat(i), 0, 0);
    idle(2);
    check("bp_window_count", n_hs, 4);

    // Mid-frame sof at (2,1).
    n_hs = 0;
    ctr_q.delete();
    for (int i = 0; i < 9; i++) begin
      send_px(pat(i), i == 0, 0);
      if (i == 0) check("sof_at_origin_no_err", bus.sync_err, 0);
    end
    send_px(8'h00, 1, 0);
    check("midsof_sync_err", bus.sync_err, 1);
    idle(1);
    check("midsof_sync_err_pulse", bus.sync_err, 0);
    for (int i = 1; i < 16; i++) send_px(pat(i), 0, 0);
    idle(2);
    check("midsof_window_count", n_hs, 4);
    if (ctr_q.size() > 0) check("midsof_first_centre", ctr_q[0], 8'h11);

    // Back-to-back frames.
    n_hs = 0;
    ctr_q.delete();
    send_frame(8'h00, 0);
    send_frame(8'h80, 0);
    idle(2);
    check("b2b_window_count", n_hs, 8);
    if (ctr_q.size() > 4) check("b2b_second_first_centre", ctr_q[4], 8'h91);

    // Asynchronous reset while a window is being presented.
    for (int i = 0; i < 11; i++) send_px(pat(i), i == 0, 0);
    bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_window", bus.out_window, 0);
    check("arst_centre", bus.out_center, 0);
    check("arst_last", bus.out_last, 0);
    check("arst_sync_err", bus.sync_err, 0);
    check("arst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    mr = 0;
    mc = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    n_hs = 0;
    run_table("s5");
    idle(2);
    check("s5_window_count", n_hs, 4);

    // Random gaps on both sides over three frames.
    n_hs = 0;
    send_frame(8'h00, 1);
    send_frame(8'h40, 1);
    send_frame(8'h80, 1);
    bus.out_ready = 1'b1;
    idle(4);
    check("rand_window_count", n_hs, 12);
    check("rand_pending_windows", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
